movavg_collect: RTL and testbench

- Downstream stage of the bit-serial moving-average filter.
- The filter emits its 64-bit 4-tap sum on a parallel bus for exactly one cycle per 64-cycle frame, and drives zero at all other cycles.
- This block tracks the same frame phase, captures the sum at the capture phase, scales it by 1/4 to form the average, and buffers results in a small FIFO.
- Results leave through a valid/ready interface so a slower consumer does not lose samples.

---
 rtl/movavg_collect.sv | 82 ++++++++
 tb/tb_movavg_collect.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/movavg_collect.sv
// Purpose : capture the filter's 4-tap sum once per 64-cycle frame, scale it to an average, buffer it.
// Latency : sample present in the capture cycle N is visible on out_data/out_valid in cycle N+1 (FIFO empty).
// Backpres: FIFO absorbs up to DEPTH samples; a capture into a full FIFO with no pop is dropped and sets overflow.
// Ports   : clk, reset (async, active-high); sum_in (64b parallel sum); out_data/out_valid/out_ready
//           (first-word-fall-through valid/ready output); level (occupancy 0..DEPTH); overflow (sticky drop flag).
module movavg_collect #(
    parameter int DEPTH         = 4,
    parameter int SHIFT         = 2,
    parameter int CAPTURE_PHASE = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              sum_in,
    output logic [63:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE_LVL  = (AW + 1)'(1);
    localparam logic [5:0]      CAP      = 6'(CAPTURE_PHASE);

    logic [5:0]    phase;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [63:0]   mem [DEPTH];

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Phase counter runs in lockstep with the filter's own frame counter,
    // so both must leave reset on the same edge.
    assign capture = (phase == CAP);
    assign full    = (count == FULL_LVL);
    assign pop     = (count != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            phase <= phase + 6'd1;
            if (push) begin
                mem[wr_ptr] <= sum_in >> SHIFT;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + ONE_LVL;
            end else if (pop && !push) begin
                count <= count - ONE_LVL;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (count != '0);
    // Head entry is shown only while valid so the bus reads zero when empty.
    assign out_data  = out_valid ? mem[rd_ptr] : 64'd0;
    assign level     = count;

endmodule

// File: tb/tb_movavg_collect.sv
// Purpose : self-checking bench for movavg_collect (table vectors, directed corner cases, random traffic).
// Latency : one cycle per stimulus step; outputs sampled just after the falling edge.
// Backpres: out_ready is driven per cycle by the stimulus.
module tb_movavg_collect;

    localparam int DEPTH = 4;
    localparam int SHIFT = 2;
    localparam int CAP   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] sum_in = 64'd0;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic        overflow;

    always #5 clk = ~clk;

    movavg_collect #(.DEPTH(DEPTH), .SHIFT(SHIFT), .CAPTURE_PHASE(CAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .sum_in    (sum_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of averages, a frame position and a drop flag.
    logic [63:0] mq[$];
    bit          m_ovf = 1'b0;
    int          m_cnt = 0;

    typedef struct {
        logic [63:0] s;
        logic        r;
        logic        ev;
        logic [63:0] ed;
        logic [2:0]  el;
        logic        eo;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] ed;
        ed = (mq.size() != 0) ? mq[0] : 64'd0;
        chk({tag, "_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_level"}, 64'(level), 64'(mq.size()));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    endtask

    task automatic model_step(input logic [63:0] s, input logic r);
        if (r && mq.size() != 0) void'(mq.pop_front());
        if (m_cnt == CAP) begin
            if (mq.size() < DEPTH) mq.push_back(s / (64'd1 << SHIFT));
            else m_ovf = 1'b1;
        end
        m_cnt = (m_cnt + 1) % 64;
    endtask

    task automatic cyc(input logic [63:0] s, input logic r, input string tag);
        @(negedge clk);
        sum_in    = s;
        out_ready = r;
        #1;
        check_model(tag);
        model_step(s, r);
    endtask

    // Assert reset between edges, check the asynchronous clear, release after the next rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        #1;
        check_model("reset_async");
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] hold_val;
        int nv;

        // Single sample at cycle 3 with ready held high.
        tbl[0] = '{64'd0,   1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[1] = '{64'd0,   1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[2] = '{64'd0,   1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[3] = '{64'd400, 1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[4] = '{64'd0,   1'b1, 1'b1, 64'd100, 3'd1, 1'b0};
        tbl[5] = '{64'd0,   1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[6] = '{64'd400, 1'b1, 1'b0, 64'd0,   3'd0, 1'b0};
        tbl[7] = '{64'd0,   1'b1, 1'b0, 64'd0,   3'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sum_in    = tbl[i].s;
            out_ready = tbl[i].r;
            #1;
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
            chk("tbl_data", out_data, tbl[i].ed);
            chk("tbl_level", 64'(level), 64'(tbl[i].el));
            chk("tbl_overflow", 64'(overflow), 64'(tbl[i].eo));
            model_step(tbl[i].s, tbl[i].r);
        end
        // Non-capture cycles carry junk; only cycle 67 may capture.
        for (int i = 8; i < 70; i++) cyc((m_cnt == CAP) ? 64'd0 : 64'd999, 1'b1, "idle");

        // Constant all-ones sum: exactly one push per frame.
        do_reset();
        nv = 0;
        for (int i = 0; i < 197; i++) begin
            cyc(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "ones");
            if (out_valid) begin
                nv++;
                chk("ones_value", out_data, 64'h3FFF_FFFF_FFFF_FFFF);
            end
        end
        chk("ones_push_count", 64'(nv), 64'd4);

        // Overflow: five captures with no consumer, then drain in order.
        do_reset();
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 64; i++)
                cyc((m_cnt == CAP) ? 64'(4 * (f + 1)) : 64'd0, 1'b0, "fill");
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc(64'd0, 1'b1, "drain");
            chk("drain_order", out_data, 64'(k));
        end
        for (int i = 0; i < 100; i++) cyc((m_cnt == CAP) ? 64'd40 : 64'd0, 1'b0, "refill");
        chk("pre_reset_level", 64'(level), 64'd2);
        chk("pre_reset_ovf", 64'(overflow), 64'd1);

        // Mid-frame reset clears everything; capture restarts at cycle 3.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(64'd80, 1'b1, "restart");
            chk("restart_valid", 64'(out_valid), 64'(i == 4));
        end

        // Full FIFO with a pop exactly on the capture cycle.
        do_reset();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 64; i++)
                cyc((m_cnt == CAP) ? 64'(4 * (f + 1)) : 64'd0, 1'b0, "fill4");
        for (int i = 0; i < 64 && m_cnt != CAP; i++) cyc(64'd0, 1'b0, "wait_cap");
        cyc(64'd20, 1'b1, "full_pop");
        cyc(64'd0, 1'b0, "after_full_pop");
        chk("full_pop_level", 64'(level), 64'd4);
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        chk("full_pop_head", out_data, 64'd2);

        // Stalled consumer: head must stay put while later captures arrive.
        do_reset();
        hold_val = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) cyc((m_cnt == CAP) ? hold_val : 64'd0, 1'b0, "hold_load");
        for (int i = 0; i < 100; i++) begin
            cyc({$urandom, $urandom}, 1'b0, "hold");
            chk("hold_data", out_data, 64'h048D_159E_26AF_37BC);
        end

        // Random traffic against the model, with one mid-run reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1700) do_reset();
            cyc({$urandom, $urandom}, (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
